// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the fetch port, the data port and the downstream memory bus.
// The arbiter takes the master view; the core/fabric environment takes the slave view.
interface mem_arbiter_if;
  logic        i_valid;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        i_error;

  logic        d_valid;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_error;

  logic        m_valid;
  logic        m_instr;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [4:0]  m_sel;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport master (
    input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, m_rdata, m_ready,
    output i_rdata, i_ready, i_error, d_rdata, d_ready, d_error,
           m_valid, m_instr, m_addr, m_wdata, m_wstrb, m_sel
  );

  modport slave (
    output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, m_rdata, m_ready,
    input  i_rdata, i_ready, i_error, d_rdata, d_ready, d_error,
           m_valid, m_instr, m_addr, m_wdata, m_wstrb, m_sel
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter with region decode onto a single memory bus; unmapped accesses error locally.
// Optional macro ARBITER_ROUND_ROBIN_EN alternates priority on contested grants.
//
// state | meaning
// IDLE  | pick a pending requester, latch and decode its access
// ISSUE | one-cycle m_valid pulse downstream
// WAIT  | hold the transaction until m_ready, forward m_rdata to the requester
// ERR   | unmapped address: return ready+error, no downstream access
module mem_arbiter #(
  parameter logic [31:0] ROM_BASE   = 32'h0,
  parameter logic [31:0] ROM_TOP    = 32'h80,
  parameter logic [31:0] UART_BASE  = 32'h1000000,
  parameter logic [31:0] UART_TOP   = 32'h1000004,
  parameter logic [31:0] CLINT_BASE = 32'h2000000,
  parameter logic [31:0] CLINT_TOP  = 32'h200C000,
  parameter logic [31:0] CLIC_BASE  = 32'h3000000,
  parameter logic [31:0] CLIC_TOP   = 32'h3005000,
  parameter logic [31:0] RAM_BASE   = 32'h80000000,
  parameter logic [31:0] RAM_TOP    = 32'h90000000
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_t;

  state_t state, state_nxt;

  logic        i_pend;
  logic [31:0] i_addr_q;
  logic        d_pend;
  logic [31:0] d_addr_q;
  logic [31:0] d_wdata_q;
  logic [3:0]  d_wstrb_q;

  logic        i_req, d_req, contested, fetch_first;
  logic        grant_i, grant_d;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic [4:0]  req_sel;

  logic        t_instr;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wstrb;
  logic [4:0]  t_sel;

  logic        wait_done, err_done;

  // Offset compare gives base <= a < top with a single unsigned compare per window.
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] base,
                                  input logic [31:0] top);
    logic [31:0] off, span;
    off    = a - base;
    span   = top - base;
    in_win = (off < span);
  endfunction

  function automatic logic [4:0] decode(input logic [31:0] a);
    logic [4:0] sel;
    sel = 5'b0;
    if      (in_win(a, ROM_BASE,   ROM_TOP))   sel = 5'b00001;
    else if (in_win(a, UART_BASE,  UART_TOP))  sel = 5'b00010;
    else if (in_win(a, CLINT_BASE, CLINT_TOP)) sel = 5'b00100;
    else if (in_win(a, CLIC_BASE,  CLIC_TOP))  sel = 5'b01000;
    else if (in_win(a, RAM_BASE,   RAM_TOP))   sel = 5'b10000;
    decode = sel;
  endfunction

`ifdef ARBITER_ROUND_ROBIN_EN
  logic last_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_d <= 1'b0;
    end else if (contested) begin
      last_d <= grant_d;
    end
  end

  assign fetch_first = last_d;
`else
  assign fetch_first = 1'b0;
`endif

  // A request pulse arriving in IDLE is granted in the same cycle without touching its slot.
  always_comb begin
    i_req     = i_pend | bus.i_valid;
    d_req     = d_pend | bus.d_valid;
    contested = (state == IDLE) && i_req && d_req;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    if (state == IDLE) begin
      if (contested) begin
        grant_i = fetch_first;
        grant_d = !fetch_first;
      end else begin
        grant_i = i_req;
        grant_d = d_req;
      end
    end
  end

  always_comb begin
    req_addr  = i_pend ? i_addr_q : bus.i_addr;
    req_wdata = 32'h0;
    req_wstrb = 4'h0;
    if (grant_d) begin
      req_addr  = d_pend ? d_addr_q  : bus.d_addr;
      req_wdata = d_pend ? d_wdata_q : bus.d_wdata;
      req_wstrb = d_pend ? d_wstrb_q : bus.d_wstrb;
    end
    req_sel = decode(req_addr);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_nxt = (req_sel != 5'b0) ? ISSUE : ERR;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (bus.m_ready) state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_pend    <= 1'b0;
      i_addr_q  <= 32'h0;
      d_pend    <= 1'b0;
      d_addr_q  <= 32'h0;
      d_wdata_q <= 32'h0;
      d_wstrb_q <= 4'h0;
    end else begin
      if (grant_i) begin
        i_pend <= 1'b0;
      end else if (bus.i_valid) begin
        i_pend   <= 1'b1;
        i_addr_q <= bus.i_addr;
      end
      if (grant_d) begin
        d_pend <= 1'b0;
      end else if (bus.d_valid) begin
        d_pend    <= 1'b1;
        d_addr_q  <= bus.d_addr;
        d_wdata_q <= bus.d_wdata;
        d_wstrb_q <= bus.d_wstrb;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      t_instr <= 1'b0;
      t_addr  <= 32'h0;
      t_wdata <= 32'h0;
      t_wstrb <= 4'h0;
      t_sel   <= 5'b0;
    end else if (grant_i || grant_d) begin
      t_instr <= grant_i;
      t_addr  <= req_addr;
      t_wdata <= req_wdata;
      t_wstrb <= req_wstrb;
      t_sel   <= req_sel;
    end
  end

  // Pulses are gated by reset so a cycle with reset high never reports activity.
  always_comb begin
    wait_done   = (state == WAIT) && bus.m_ready && !reset;
    err_done    = (state == ERR) && !reset;

    bus.m_valid = (state == ISSUE) && !reset;
    bus.m_instr = t_instr;
    bus.m_addr  = t_addr;
    bus.m_wdata = t_wdata;
    bus.m_wstrb = t_wstrb;
    bus.m_sel   = t_sel;

    bus.i_ready = t_instr && (wait_done || err_done);
    bus.i_error = t_instr && err_done;
    bus.i_rdata = (t_instr && wait_done) ? bus.m_rdata : 32'h0;

    bus.d_ready = !t_instr && (wait_done || err_done);
    bus.d_error = !t_instr && err_done;
    bus.d_rdata = (!t_instr && wait_done) ? bus.m_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard queues of expected bus transactions and responses.
// Honours ARBITER_ROUND_ROBIN_EN for the second simultaneous-request case.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [4:0]  sel;
  } mtxn_t;

  typedef struct packed {
    logic        instr;
    logic        err;
    logic [31:0] rdata;
  } resp_t;

  mtxn_t exp_m[$];
  resp_t exp_r[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit i_busy = 0;
  bit d_busy = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] all_outs();
    return 160'({bus.m_valid, bus.m_instr, bus.m_addr, bus.m_wdata, bus.m_wstrb, bus.m_sel,
                 bus.i_ready, bus.i_error, bus.i_rdata,
                 bus.d_ready, bus.d_error, bus.d_rdata});
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fetch(input logic [31:0] addr, input logic [4:0] sel, input logic [31:0] rdata);
    check("i_one_outstanding", 160'(i_busy), 160'(0));
    i_busy = 1;
    bus.i_valid = 1'b1;
    bus.i_addr  = addr;
    if (sel != 5'b0) exp_m.push_back('{1'b1, addr, 32'h0, 4'h0, sel});
    exp_r.push_back('{1'b1, (sel == 5'b0), (sel == 5'b0) ? 32'h0 : rdata});
  endtask

  task automatic push_data(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                           input logic [4:0] sel, input logic [31:0] rdata);
    check("d_one_outstanding", 160'(d_busy), 160'(0));
    d_busy = 1;
    bus.d_valid = 1'b1;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_wstrb = wstrb;
    if (sel != 5'b0) exp_m.push_back('{1'b0, addr, wdata, wstrb, sel});
    exp_r.push_back('{1'b0, (sel == 5'b0), (sel == 5'b0) ? 32'h0 : rdata});
  endtask

  // End the request cycle and scramble the request buses so only latched values can reach m_*.
  task automatic end_req();
    next_cycle();
    bus.i_valid = 1'b0;
    bus.d_valid = 1'b0;
    bus.i_addr  = 32'hFFFF_FFF0;
    bus.d_addr  = 32'hFFFF_FFF0;
    bus.d_wdata = 32'h5555_AAAA;
    bus.d_wstrb = 4'h6;
  endtask

  task automatic check_resp(input resp_t er);
    if (er.instr) begin
      check("i_ready", 160'(bus.i_ready), 160'(1));
      check("i_error", 160'(bus.i_error), 160'(er.err));
      check("i_rdata", 160'(bus.i_rdata), 160'(er.rdata));
      check("d_ready_quiet", 160'(bus.d_ready), 160'(0));
      i_busy = 0;
    end else begin
      check("d_ready", 160'(bus.d_ready), 160'(1));
      check("d_error", 160'(bus.d_error), 160'(er.err));
      check("d_rdata", 160'(bus.d_rdata), 160'(er.rdata));
      check("i_ready_quiet", 160'(bus.i_ready), 160'(0));
      d_busy = 0;
    end
  endtask

  // Wait for m_valid, compare the downstream transaction, answer after 'delay' cycles.
  task automatic serve(input int delay, input int exp_wait);
    mtxn_t em;
    resp_t er;
    int    waited;
    bit    seen;
    waited = 0;
    seen   = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.m_valid === 1'b1) begin
        seen = 1;
        break;
      end
      waited++;
      next_cycle();
    end
    check("m_valid_seen", 160'(seen), 160'(1));
    if (!seen || exp_m.size() == 0 || exp_r.size() == 0) return;
    em = exp_m.pop_front();
    er = exp_r.pop_front();
    check("issue_wait", 160'(waited), 160'(exp_wait));
    check("m_instr", 160'(bus.m_instr), 160'(em.instr));
    check("m_addr",  160'(bus.m_addr),  160'(em.addr));
    check("m_wdata", 160'(bus.m_wdata), 160'(em.wdata));
    check("m_wstrb", 160'(bus.m_wstrb), 160'(em.wstrb));
    check("m_sel",   160'(bus.m_sel),   160'(em.sel));
    check("no_ready_at_issue", 160'({bus.i_ready, bus.d_ready}), 160'(0));
    for (int k = 1; k <= delay; k++) begin
      next_cycle();
      if (k == delay) begin
        bus.m_ready = 1'b1;
        bus.m_rdata = er.rdata;
      end
      @(negedge clk);
      check("m_valid_one_cycle", 160'(bus.m_valid), 160'(0));
      check("wait_hold", 160'({bus.m_addr, bus.m_sel, bus.m_wstrb}),
            160'({em.addr, em.sel, em.wstrb}));
      if (k < delay) check("no_early_ready", 160'({bus.i_ready, bus.d_ready}), 160'(0));
    end
    check_resp(er);
    next_cycle();
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
  endtask

  // Unmapped access: ready+error the cycle after the request, nothing downstream.
  task automatic finish_err();
    resp_t er;
    @(negedge clk);
    check("err_no_m_valid", 160'(bus.m_valid), 160'(0));
    check("err_m_sel", 160'(bus.m_sel), 160'(0));
    if (exp_r.size() == 0) return;
    er = exp_r.pop_front();
    check_resp(er);
    next_cycle();
    @(negedge clk);
    check("err_ready_pulse", 160'({bus.i_ready, bus.d_ready, bus.m_valid}), 160'(0));
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_addr  = 32'h0;
    bus.d_valid = 1'b0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.d_wstrb = 4'h0;
    bus.m_rdata = 32'h0;
    bus.m_ready = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("reset_outputs", all_outs(), 160'(0));
    next_cycle();
    reset = 1'b0;

    // Stray m_ready while idle must be ignored.
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h1234_5678;
    @(negedge clk);
    check("idle_m_ready_ignored", all_outs(), 160'(0));
    next_cycle();
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;

    push_fetch(32'h40, 5'b00001, 32'hDEAD_BEEF);
    end_req();
    serve(3, 0);

    push_data(32'h0100_0000, 32'h41, 4'hF, 5'b00010, 32'h0000_1234);
    end_req();
    serve(1, 0);

    push_data(32'h4000_0000, 32'h0, 4'h0, 5'b00000, 32'h0);
    end_req();
    finish_err();

    push_data(32'h0200_BFFC, 32'h0, 4'h0, 5'b00100, 32'h0000_0C11);
    end_req();
    serve(1, 0);

    push_data(32'h0200_C000, 32'h0, 4'h0, 5'b00000, 32'h0);
    end_req();
    finish_err();

    push_data(32'h8FFF_FFFC, 32'hCAFE_0001, 4'h1, 5'b10000, 32'h0000_0777);
    end_req();
    serve(2, 0);

    push_fetch(32'h9000_0000, 5'b00000, 32'h0);
    end_req();
    finish_err();

    push_data(32'h0300_4FFC, 32'h0, 4'h0, 5'b01000, 32'h0000_C1C0);
    end_req();
    serve(1, 0);

    // First tie: data wins in both builds; fetch issues two cycles after data's ready.
    push_data(32'h8000_0010, 32'h0000_00AA, 4'h3, 5'b10000, 32'h1111_0000);
    push_fetch(32'h44, 5'b00001, 32'h2222_0000);
    end_req();
    serve(1, 0);
    serve(1, 1);

    // Second tie: round-robin hands it to fetch, fixed priority keeps data first.
`ifdef ARBITER_ROUND_ROBIN_EN
    push_fetch(32'h48, 5'b00001, 32'h3333_0000);
    push_data(32'h8000_0020, 32'h0000_00BB, 4'hC, 5'b10000, 32'h4444_0000);
`else
    push_data(32'h8000_0020, 32'h0000_00BB, 4'hC, 5'b10000, 32'h4444_0000);
    push_fetch(32'h48, 5'b00001, 32'h3333_0000);
`endif
    bus.i_valid = 1'b1;
    bus.d_valid = 1'b1;
    end_req();
    serve(2, 0);
    serve(1, 1);

    // Reset during WAIT abandons the access; the late m_ready is ignored.
    bus.i_valid = 1'b1;
    bus.i_addr  = 32'h10;
    end_req();
    next_cycle();
    @(negedge clk);
    check("rst_pre_addr", 160'({bus.m_valid, bus.m_addr}), 160'({1'b0, 32'h10}));
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.m_ready = 1'b1;
    bus.m_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    check("rst_midtxn_outputs", all_outs(), 160'(0));
    next_cycle();
    bus.m_ready = 1'b0;
    bus.m_rdata = 32'h0;
    @(negedge clk);
    check("rst_no_late_ready", 160'({bus.i_ready, bus.d_ready, bus.m_valid}), 160'(0));
    i_busy = 0;
    next_cycle();

    push_fetch(32'h7C, 5'b00001, 32'h0F0F_0F0F);
    end_req();
    serve(2, 0);

    check("scoreboard_drained", 160'({exp_m.size(), exp_r.size()}), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
